// File: rtl/router_pkg.sv
// Shared router definitions.
// Holds the byte width, the per-port buffer depth, the header-flag bit
// position, the header payload-length field and the destination address
// codes used by the synchronizer, the FSM and the output buffers.
package router_pkg;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int HDR_BIT = DW;

  // Header byte layout: [7:2] payload length, [1:0] destination.
  localparam int LEN_HI = 7;
  localparam int LEN_LO = 2;

  typedef enum logic [1:0] {
    DEST_0   = 2'b00,
    DEST_1   = 2'b01,
    DEST_2   = 2'b10,
    DEST_INV = 2'b11
  } dest_e;

  // Bytes still to be read after the header: payload plus parity.
  function automatic logic [6:0] pkt_len(input logic [7:0] hdr);
    return {1'b0, hdr[LEN_HI:LEN_LO]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Output-buffer bus between the synchronizer/destination side (master)
// and one router_fifo instance (slave).
//   soft_rst, wr_en, lfd_state, data_in, rd_en : master -> fifo
//   data_out, full, empty, pkt_active, pkt_err : fifo -> master
interface router_fifo_if #(
  parameter int DW = router_pkg::DW
);
  logic          soft_rst;
  logic          wr_en;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          pkt_active;
  logic          pkt_err;

  modport master (
    output soft_rst, wr_en, lfd_state, data_in, rd_en,
    input  data_out, full, empty, pkt_active, pkt_err
  );

  modport slave (
    input  soft_rst, wr_en, lfd_state, data_in, rd_en,
    output data_out, full, empty, pkt_active, pkt_err
  );
endinterface

// File: rtl/router_fifo_ptr.sv
// AW+1-bit wrapping pointer for the output buffer. The extra MSB is the
// wrap bit that distinguishes full from empty.
//   clk, rst (sync, active-low), clr (sync clear), inc (advance by one),
//   ptr (current value).
module router_fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + (AW+1)'(1);
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer of the router. Stores header/payload/
// parity bytes with a header flag, reports full/empty to the
// synchronizer, and tracks packet boundaries on the read side.
//   clk          clock
//   rst          synchronous, active-low reset (clears everything)
//   bus (slave)  soft_rst/wr_en/lfd_state/data_in/rd_en in,
//                data_out/full/empty/pkt_active/pkt_err out
module router_fifo #(
  parameter int DW    = router_pkg::DW,
  parameter int DEPTH = router_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  router_fifo_if.slave      bus
);
  import router_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   entry;
  logic [6:0]    rem;
  logic          wr_ok;
  logic          rd_ok;

  // full/empty decode the registered pointers before the edge, so a
  // simultaneous access while full drops the write and while empty
  // ignores the read. soft_rst discards any same-cycle access.
  assign bus.empty = (wp == rp);
  assign bus.full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign wr_ok     = rst && !bus.soft_rst && bus.wr_en && !bus.full;
  assign rd_ok     = rst && !bus.soft_rst && bus.rd_en && !bus.empty;
  assign entry     = mem[rp[AW-1:0]];

  router_fifo_ptr #(.AW(AW)) u_wp (
    .clk (clk),
    .rst (rst),
    .clr (bus.soft_rst),
    .inc (wr_ok),
    .ptr (wp)
  );

  router_fifo_ptr #(.AW(AW)) u_rp (
    .clk (clk),
    .rst (rst),
    .clr (bus.soft_rst),
    .inc (rd_ok),
    .ptr (rp)
  );

  // Storage is never reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wp[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  // Read stage: registered data and remaining-byte counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.data_out <= '0;
      rem          <= '0;
      bus.pkt_err  <= 1'b0;
    end else if (bus.soft_rst) begin
      bus.data_out <= '0;
      rem          <= '0;
    end else if (rd_ok) begin
      bus.data_out <= entry[DW-1:0];
      if (entry[DW])
        rem <= pkt_len(entry[7:0]);   // a header mid-packet simply restarts
      else if (rem != 7'd0)
        rem <= rem - 7'd1;
      else
        bus.pkt_err <= 1'b1;          // payload byte with no open packet
    end
  end

  assign bus.pkt_active = (rem != 7'd0);

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  logic clk = 1'b0;
  logic rst;
  int   ncmp  = 0;
  int   nfail = 0;

  router_fifo_if #(.DW(8)) bus ();

  router_fifo #(.DW(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    bus.wr_en     = 1'b1;
    bus.data_in   = d;
    bus.lfd_state = lfd;
    tick();
    bus.wr_en     = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic rd();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.soft_rst  = 1'b0;
    bus.wr_en     = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'h00;
    bus.rd_en     = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_empty",  bus.empty,      1);
    check("rst_full",   bus.full,       0);
    check("rst_dout",   bus.data_out,   8'h00);
    check("rst_active", bus.pkt_active, 0);
    check("rst_err",    bus.pkt_err,    0);
    rst = 1'b1;
    tick();

    // Full packet: header 0x0D (length 3) + 3 payload + parity
    wr(8'h0D, 1'b1);
    check("pkt_empty_after_wr", bus.empty, 0);
    wr(8'hA1, 1'b0);
    wr(8'hA2, 1'b0);
    wr(8'hA3, 1'b0);
    wr(8'h5F, 1'b0);
    check("pkt_active_before", bus.pkt_active, 0);
    rd();
    check("pkt_hdr",     bus.data_out,   8'h0D);
    check("pkt_act_hdr", bus.pkt_active, 1);
    rd();
    check("pkt_b1",      bus.data_out,   8'hA1);
    check("pkt_act_b1",  bus.pkt_active, 1);
    rd();
    check("pkt_b2",      bus.data_out,   8'hA2);
    rd();
    check("pkt_b3",      bus.data_out,   8'hA3);
    check("pkt_act_b3",  bus.pkt_active, 1);
    rd();
    check("pkt_par",     bus.data_out,   8'h5F);
    check("pkt_act_par", bus.pkt_active, 0);
    check("pkt_empty",   bus.empty,      1);
    check("pkt_err_ok",  bus.pkt_err,    0);
    tick();
    check("pkt_dout_hold", bus.data_out, 8'h5F);

    // Error path: payload byte with no open packet
    wr(8'h77, 1'b0);
    rd();
    check("err_dout", bus.data_out, 8'h77);
    check("err_set",  bus.pkt_err,  1);
    tick();
    check("err_sticky", bus.pkt_err, 1);

    // Full / overflow
    for (int i = 0; i < 17; i++) begin
      wr(8'(i), 1'b0);
      if (i == 14) check("ovf_not_full_15", bus.full, 0);
      if (i == 15) check("ovf_full_16",     bus.full, 1);
    end
    check("ovf_full_17", bus.full, 1);
    // Simultaneous access while full: read happens, write dropped
    bus.rd_en   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.data_in = 8'hEE;
    tick();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    check("ovf_rdwr_dout", bus.data_out, 8'h00);
    check("ovf_rdwr_full", bus.full,     0);
    for (int i = 1; i < 16; i++) begin
      rd();
      check($sformatf("ovf_rd_%0d", i), bus.data_out, 8'(i));
    end
    check("ovf_drained", bus.empty, 1);
    rd();
    check("ovf_rd_empty_ignored", bus.data_out, 8'h0F);
    check("ovf_err_kept", bus.pkt_err, 1);

    // Soft reset with concurrent write
    for (int i = 0; i < 6; i++) wr(8'h20 + 8'(i), 1'b0);
    check("srst_pre_empty", bus.empty, 0);
    bus.soft_rst = 1'b1;
    bus.wr_en    = 1'b1;
    bus.data_in  = 8'h99;
    tick();
    bus.soft_rst = 1'b0;
    bus.wr_en    = 1'b0;
    check("srst_empty",  bus.empty,      1);
    check("srst_dout",   bus.data_out,   8'h00);
    check("srst_active", bus.pkt_active, 0);
    check("srst_err",    bus.pkt_err,    1);
    // Simultaneous write and read while empty: no bypass
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.data_in = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("srst_nobypass_dout",  bus.data_out, 8'h00);
    check("srst_nobypass_empty", bus.empty,    0);
    rd();
    check("srst_3c",       bus.data_out, 8'h3C);
    check("srst_3c_empty", bus.empty,    1);

    // Hard reset clears the sticky error
    rst = 1'b0;
    tick();
    tick();
    check("rst2_err",   bus.pkt_err,  0);
    check("rst2_empty", bus.empty,    1);
    check("rst2_dout",  bus.data_out, 8'h00);
    rst = 1'b1;
    tick();

    // Wrap and simultaneous access: 10 stored, 20 concurrent cycles
    for (int i = 0; i < 10; i++) wr(8'h40 + 8'(i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.data_in = 8'h40 + 8'(k + 10);
      tick();
      check($sformatf("wrap_d_%0d", k), bus.data_out, 8'h40 + 8'(k));
      check($sformatf("wrap_f_%0d", k), bus.full,  0);
      check($sformatf("wrap_e_%0d", k), bus.empty, 0);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd();
      check($sformatf("wrap_drain_%0d", i), bus.data_out, 8'h40 + 8'(i + 20));
    end
    check("wrap_empty", bus.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
